// File: rtl/accum_ctrl_pkg.sv
// Shared definitions for the accumulator controller: default sizes and FSM state encoding.
package accum_defs;

    localparam int unsigned DEF_WIDTH = 8;
    localparam int unsigned DEF_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/accum_ctrl_if.sv
// Bundles the start/len request, operand input handshake and result output handshake.
interface accum_ctrl_if
    import accum_defs::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = DEF_CNT_W
);

    logic             start;
    logic [CNT_W-1:0] len;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_ovf;
    logic             busy;

    modport master (
        output start, len, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sum, out_ovf, busy
    );

    modport slave (
        input  start, len, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sum, out_ovf, busy
    );

endinterface

// File: rtl/accum_ctrl_full_adder.sv
// Combinational WIDTH-bit adder; c[0] carries the carry-out, upper bits of c are always zero.
module full_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] c
);

    logic [WIDTH:0] total;

    always_comb begin
        total = {1'b0, a} + {1'b0, b};
        s     = total[WIDTH-1:0];
        c     = '0;
        c[0]  = total[WIDTH];
    end

endmodule

// File: rtl/accum_ctrl.sv
// Sequence-summation controller: accepts LEN operands, accumulates through full_adder,
// then offers the wrapped sum and a sticky carry flag on the output handshake.
module accum_ctrl
    import accum_defs::*;
#(
    parameter int unsigned WIDTH = DEF_WIDTH,
    parameter int unsigned CNT_W = DEF_CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    accum_ctrl_if.slave  bus
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] len_q, len_d;

    logic [WIDTH-1:0] add_s;
    logic [WIDTH-1:0] add_c;
    logic             carry;

    full_adder #(.WIDTH(WIDTH)) u_full_adder (
        .a (acc_q),
        .b (bus.in_data),
        .s (add_s),
        .c (add_c)
    );

    // Upper carry bits are guaranteed zero, so reducing the whole vector equals c[0].
    assign carry = |add_c;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        len_d   = len_q;
        case (state_q)
            ST_IDLE: begin
                if (bus.start) begin
                    len_d   = bus.len;
                    acc_d   = '0;
                    cnt_d   = '0;
                    ovf_d   = 1'b0;
                    state_d = (bus.len == '0) ? ST_DONE : ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                if (bus.in_valid) begin
                    acc_d = add_s;
                    ovf_d = ovf_q | carry;
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == len_q - CNT_W'(1)) begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            acc_q   <= '0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
            len_q   <= len_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_ACCUM);
    assign bus.out_valid = (state_q == ST_DONE);
    assign bus.busy      = (state_q != ST_IDLE);
    assign bus.out_sum   = acc_q;
    assign bus.out_ovf   = ovf_q;

endmodule

// File: tb/tb_accum_ctrl.sv
// Self-checking bench for accum_ctrl: directed scenarios plus randomized runs against a
// transaction-level model (list of accepted operands, result = plain integer sum).
module tb_accum_ctrl;
    import accum_defs::*;

    localparam int W  = 8;
    localparam int CW = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    accum_ctrl_if #(.WIDTH(W), .CNT_W(CW)) bus ();

    accum_ctrl #(.WIDTH(W), .CNT_W(CW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: protocol phase plus the list of operands accepted in the current run.
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_RES  = 2;

    int m_phase = M_IDLE;
    int m_len   = 0;
    int m_ops[$];

    function automatic int m_total();
        int t = 0;
        foreach (m_ops[i]) t += m_ops[i];
        return t;
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= M_IDLE;
            m_len   <= 0;
            m_ops.delete();
        end else begin
            case (m_phase)
                M_IDLE: if (bus.start) begin
                    m_len <= int'(bus.len);
                    m_ops.delete();
                    m_phase <= (bus.len == 0) ? M_RES : M_RUN;
                end
                M_RUN: if (bus.in_valid) begin
                    m_ops.push_back(int'(bus.in_data));
                    if (m_ops.size() == m_len) m_phase <= M_RES;
                end
                M_RES: if (bus.out_ready) m_phase <= M_IDLE;
                default: m_phase <= M_IDLE;
            endcase
        end
    end

    // Compare process: every falling edge, outputs must match the model.
    always @(negedge clk) begin
        check("cmp_in_ready",  32'(bus.in_ready),  32'(m_phase == M_RUN));
        check("cmp_out_valid", 32'(bus.out_valid), 32'(m_phase == M_RES));
        check("cmp_busy",      32'(bus.busy),      32'(m_phase != M_IDLE));
        if (!rst_n || m_phase == M_RES) begin
            check("cmp_out_sum", 32'(bus.out_sum), 32'(m_total() % 256));
            check("cmp_out_ovf", 32'(bus.out_ovf), 32'(m_total() >= 256));
        end
    end

    task automatic begin_run(input int l);
        @(negedge clk);
        bus.start = 1'b1;
        bus.len   = CW'(l);
        @(negedge clk);
        bus.start = 1'b0;
        bus.len   = '0;
    endtask

    task automatic feed(input int op, input int gap, input bit poke_start);
        bus.in_valid = 1'b1;
        bus.in_data  = W'(op);
        if (poke_start) begin
            bus.start = 1'b1;
            bus.len   = CW'($urandom_range(0, 15));
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.start    = 1'b0;
        repeat (gap) @(negedge clk);
    endtask

    task automatic collect(input string tag, input int es, input int eo, input int hold);
        int n = 0;
        while (!bus.out_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
        check({tag, "_sum"},   32'(bus.out_sum),   32'(es));
        check({tag, "_ovf"},   32'(bus.out_ovf),   32'(eo));
        repeat (hold) @(negedge clk);
        if (hold > 0) check({tag, "_held_sum"}, 32'(bus.out_sum), 32'(es));
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, "_idle"}, 32'(bus.busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int tot;
        int l;
        int op;
        bus.start     = 1'b0;
        bus.len       = '0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.out_ready = 1'b0;

        repeat (2) @(negedge clk);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_out_sum",   32'(bus.out_sum),   32'd0);
        rst_n = 1'b1;

        // Basic run: result appears on the edge accepting the 4th operand.
        begin_run(4);
        feed(1, 0, 1'b0);
        feed(2, 0, 1'b0);
        feed(3, 0, 1'b0);
        feed(4, 0, 1'b0);
        check("t2_valid_latency", 32'(bus.out_valid), 32'd1);
        collect("t2", 10, 0, 0);

        // Overflow, then a fresh run clears the flag.
        begin_run(2);
        feed(200, 0, 1'b0);
        feed(100, 0, 1'b0);
        collect("t3a", 44, 1, 0);
        begin_run(1);
        feed(5, 0, 1'b0);
        collect("t3b", 5, 0, 0);

        // Stalls on input and backpressure on output.
        begin_run(3);
        feed(7, 2, 1'b0);
        feed(8, 2, 1'b0);
        feed(9, 0, 1'b0);
        collect("t4", 24, 0, 5);

        // Zero length, then start pulses mid-run are ignored.
        begin_run(0);
        check("t5_zero_valid", 32'(bus.out_valid), 32'd1);
        collect("t5a", 0, 0, 0);
        begin_run(2);
        feed(1, 0, 1'b1);
        feed(1, 0, 1'b1);
        collect("t5b", 2, 0, 0);

        // Maximum run length.
        begin_run(15);
        for (int i = 0; i < 15; i++) feed(17, 0, 1'b0);
        check("t6_accepts", 32'(m_ops.size()), 32'd15);
        collect("t6", 255, 0, 0);

        // Asynchronous reset in the middle of a run.
        begin_run(3);
        feed(10, 0, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("t1_in_ready", 32'(bus.in_ready),  32'd0);
        check("t1_valid",    32'(bus.out_valid), 32'd0);
        check("t1_busy",     32'(bus.busy),      32'd0);
        check("t1_sum",      32'(bus.out_sum),   32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Randomized runs.
        for (int r = 0; r < 25; r++) begin
            l = $urandom_range(0, 15);
            begin_run(l);
            tot = 0;
            for (int i = 0; i < l; i++) begin
                op = $urandom_range(0, 255);
                tot += op;
                feed(op, $urandom_range(0, 2), ($urandom_range(0, 3) == 0));
            end
            collect("rnd", tot % 256, (tot >= 256) ? 1 : 0, $urandom_range(0, 3));
        end

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
